// File: rtl/linebuf_feeder.sv
// linebuf_feeder
//   Reads an img_size x img_size image (row-major, starting at base_addr)
//   from a memory with one cycle of read latency. It streams the pixels to a
//   line buffer at one pixel per cycle, with no gaps. buf_en pulses together
//   with pixel 0.
//
// Ports
//   clk        : clock, rising edge
//   xrst       : asynchronous active-high reset
//   req        : start request, sampled only in IDLE
//   img_size   : image edge length (N = img_size*img_size pixels)
//   base_addr  : address of pixel (0,0)
//   mem_re     : memory read enable
//   mem_addr   : memory read address (0 when mem_re=0)
//   mem_rdata  : memory read data, valid one cycle after mem_re
//   buf_en     : one-cycle start pulse to the line buffer
//   buf_input  : pixel stream (mem_rdata passed through during STREAM)
//   busy       : high whenever not IDLE
//   done       : one-cycle completion pulse
module linebuf_feeder #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 10,
  parameter int MWIDTH = 20
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     req,
  input  logic [LWIDTH-1:0]        img_size,
  input  logic [MWIDTH-1:0]        base_addr,
  output logic                     mem_re,
  output logic [MWIDTH-1:0]        mem_addr,
  input  logic signed [DWIDTH-1:0] mem_rdata,
  output logic                     buf_en,
  output logic signed [DWIDTH-1:0] buf_input,
  output logic                     busy,
  output logic                     done
);

  localparam int NW = 2 * LWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_STREAM   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t            state_r;
  logic [NW-1:0]     n_r;
  logic [NW-1:0]     cnt_r;
  logic [MWIDTH-1:0] base_r;
  logic              mem_re_r;
  logic [MWIDTH-1:0] mem_addr_r;
  logic              buf_en_r;
  logic              busy_r;
  logic              done_r;
  logic              last_s;

  // Current STREAM cycle carries the final pixel.
  assign last_s = (cnt_r == (n_r - NW'(1)));

  // Control FSM. Every output is registered as the value for the next cycle.
  // Reads run one cycle ahead of the stream because of the memory latency.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_r    <= ST_IDLE;
      n_r        <= {NW{1'b0}};
      cnt_r      <= {NW{1'b0}};
      base_r     <= {MWIDTH{1'b0}};
      mem_re_r   <= 1'b0;
      mem_addr_r <= {MWIDTH{1'b0}};
      buf_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r    <= {NW{1'b0}};
          buf_en_r <= 1'b0;
          done_r   <= 1'b0;
          if (req && (img_size != {LWIDTH{1'b0}})) begin
            state_r    <= ST_PREFETCH;
            n_r        <= NW'(img_size) * NW'(img_size);
            base_r     <= base_addr;
            mem_re_r   <= 1'b1;
            mem_addr_r <= base_addr;
            busy_r     <= 1'b1;
          end else if (req) begin
            // Empty image: finish without touching memory or the buffer.
            state_r    <= ST_DONE;
            mem_re_r   <= 1'b0;
            mem_addr_r <= {MWIDTH{1'b0}};
            busy_r     <= 1'b1;
            done_r     <= 1'b1;
          end else begin
            mem_re_r   <= 1'b0;
            mem_addr_r <= {MWIDTH{1'b0}};
            busy_r     <= 1'b0;
          end
        end
        ST_PREFETCH: begin
          state_r  <= ST_STREAM;
          cnt_r    <= {NW{1'b0}};
          buf_en_r <= 1'b1;
          busy_r   <= 1'b1;
          done_r   <= 1'b0;
          if (n_r > NW'(1)) begin
            mem_re_r   <= 1'b1;
            mem_addr_r <= base_r + MWIDTH'(1);
          end else begin
            mem_re_r   <= 1'b0;
            mem_addr_r <= {MWIDTH{1'b0}};
          end
        end
        ST_STREAM: begin
          buf_en_r <= 1'b0;
          busy_r   <= 1'b1;
          if (last_s) begin
            state_r    <= ST_DONE;
            mem_re_r   <= 1'b0;
            mem_addr_r <= {MWIDTH{1'b0}};
            done_r     <= 1'b1;
          end else begin
            cnt_r  <= cnt_r + NW'(1);
            done_r <= 1'b0;
            // Next cycle is k+1; it reads pixel k+2 unless k+1 is the last.
            if ((cnt_r + NW'(2)) < n_r) begin
              mem_re_r   <= 1'b1;
              mem_addr_r <= base_r + MWIDTH'(cnt_r) + MWIDTH'(2'd2);
            end else begin
              mem_re_r   <= 1'b0;
              mem_addr_r <= {MWIDTH{1'b0}};
            end
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          cnt_r      <= {NW{1'b0}};
          mem_re_r   <= 1'b0;
          mem_addr_r <= {MWIDTH{1'b0}};
          buf_en_r   <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= {NW{1'b0}};
          mem_re_r   <= 1'b0;
          mem_addr_r <= {MWIDTH{1'b0}};
          buf_en_r   <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign mem_re   = mem_re_r;
  assign mem_addr = mem_addr_r;
  assign buf_en   = buf_en_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Pixel data goes straight through from memory; forced to 0 outside STREAM.
  assign buf_input = (state_r == ST_STREAM) ? mem_rdata : {DWIDTH{1'b0}};

endmodule

// File: tb/tb_linebuf_feeder.sv
module tb_linebuf_feeder;

  logic               clk = 1'b0;
  logic               xrst;
  logic               req;
  logic [9:0]         img_size;
  logic [19:0]        base_addr;
  logic               mem_re;
  logic [19:0]        mem_addr;
  logic signed [15:0] mem_rdata;
  logic               buf_en;
  logic signed [15:0] buf_input;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;
  int re_cnt = 0;

  linebuf_feeder #(.DWIDTH(16), .LWIDTH(10), .MWIDTH(20)) dut (
    .clk(clk), .xrst(xrst), .req(req), .img_size(img_size),
    .base_addr(base_addr), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .buf_en(buf_en), .buf_input(buf_input),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = a (low 16 bits), one cycle read latency.
  always @(posedge clk or posedge xrst) begin
    if (xrst) mem_rdata <= 16'sd0;
    else if (mem_re === 1'b1) mem_rdata <= mem_addr[15:0];
  end

  // Count issued reads.
  always @(posedge clk) begin
    if (mem_re === 1'b1) re_cnt = re_cnt + 1;
  end

  task automatic chk(input string tag, input logic eb, input logic ere,
                     input logic [19:0] ea, input logic een,
                     input logic [15:0] ein, input logic ed);
    checks++;
    assert (busy === eb) else begin errors++;
      $error("FAIL %s busy got=%0h exp=%0h", tag, busy, eb); end
    checks++;
    assert (mem_re === ere) else begin errors++;
      $error("FAIL %s mem_re got=%0h exp=%0h", tag, mem_re, ere); end
    checks++;
    assert (mem_addr === ea) else begin errors++;
      $error("FAIL %s mem_addr got=%0h exp=%0h", tag, mem_addr, ea); end
    checks++;
    assert (buf_en === een) else begin errors++;
      $error("FAIL %s buf_en got=%0h exp=%0h", tag, buf_en, een); end
    checks++;
    assert (buf_input === ein) else begin errors++;
      $error("FAIL %s buf_input got=%0h exp=%0h", tag, buf_input, ein); end
    checks++;
    assert (done === ed) else begin errors++;
      $error("FAIL %s done got=%0h exp=%0h", tag, done, ed); end
  endtask

  // Caller has set req/img_size/base_addr before the sampling edge.
  // After PREFETCH, inputs switch to hold_req/next_img/next_base.
  task automatic run_full(input string tag, input int n, input logic [19:0] base,
                          input logic hold_req, input logic [9:0] next_img,
                          input logic [19:0] next_base);
    logic [19:0] a;
    logic [19:0] ai;
    re_cnt = 0;
    @(negedge clk);
    chk({tag, "_pre"}, 1'b1, 1'b1, base, 1'b0, 16'h0000, 1'b0);
    req = hold_req; img_size = next_img; base_addr = next_base;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a  = base + 20'(k + 1);
      ai = base + 20'(k);
      chk($sformatf("%s_k%0d", tag, k), 1'b1, (k < n - 1),
          (k < n - 1) ? a : 20'h00000, (k == 0), ai[15:0], 1'b0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 1'b1, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    chk({tag, "_idle"}, 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    checks++;
    assert (re_cnt == n) else begin errors++;
      $error("FAIL %s reads got=%0d exp=%0d", tag, re_cnt, n); end
  endtask

  initial begin
    xrst = 1'b1; req = 1'b0; img_size = 10'd0; base_addr = 20'h00000;
    #1;
    chk("reset_async", 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    req = 1'b1; img_size = 10'd3;
    @(negedge clk); @(negedge clk);
    chk("reset_held", 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    req = 1'b0;
    xrst = 1'b0;
    @(negedge clk);
    chk("idle", 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0);

    // Nominal 3x3 from 0x100; inputs scrambled mid-run must not matter.
    req = 1'b1; img_size = 10'd3; base_addr = 20'h00100;
    run_full("nom", 9, 20'h00100, 1'b0, 10'd7, 20'h5A5A5);

    // Single pixel.
    req = 1'b1; img_size = 10'd1; base_addr = 20'h0002A;
    run_full("one", 1, 20'h0002A, 1'b0, 10'd0, 20'h00000);

    // Zero size: done next cycle, no read, no buf_en.
    re_cnt = 0;
    req = 1'b1; img_size = 10'd0; base_addr = 20'h00200;
    @(negedge clk);
    req = 1'b0;
    chk("zero_done", 1'b1, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    chk("zero_idle", 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    checks++;
    assert (re_cnt == 0) else begin errors++;
      $error("FAIL zero_reads got=%0d exp=0", re_cnt); end

    // Address wrap at 2^20.
    req = 1'b1; img_size = 10'd2; base_addr = 20'hFFFFE;
    run_full("wrap", 4, 20'hFFFFE, 1'b0, 10'd2, 20'h00000);

    // req held high: first run 2x2, img_size raised to 4 mid-run;
    // second run starts only after one IDLE cycle and streams 16.
    req = 1'b1; img_size = 10'd2; base_addr = 20'h00300;
    run_full("hold1", 4, 20'h00300, 1'b1, 10'd4, 20'h00400);
    run_full("hold2", 16, 20'h00400, 1'b0, 10'd4, 20'h00400);

    // Reset during STREAM k=5 of a 4x4 run.
    req = 1'b1; img_size = 10'd4; base_addr = 20'h00040;
    @(negedge clk);
    chk("rst_pre", 1'b1, 1'b1, 20'h00040, 1'b0, 16'h0000, 1'b0);
    req = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    chk("rst_k5", 1'b1, 1'b1, 20'h00046, 1'b0, 16'h0045, 1'b0);
    xrst = 1'b1;
    #1;
    chk("rst_abort", 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("rst_nodone", 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    xrst = 1'b0;
    @(negedge clk);
    chk("rst_idle", 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    req = 1'b1; img_size = 10'd2; base_addr = 20'h00080;
    run_full("after_rst", 4, 20'h00080, 1'b0, 10'd2, 20'h00080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
